// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: types and helpers shared by the bit-serial subtractor.
//   state_e : controller states (IDLE, SHIFT, DONE), 2-bit encoding
//   cnt_w() : width of the bit counter for a given operand width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// full_sub: combinational single-bit full subtractor cell.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit   (x ^ y ^ bin)
//   bout : borrow out       (1 when x < y + bin)
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full_sub cell
// reused for WIDTH cycles. Operands enter through in_valid/in_ready, the
// result leaves through out_valid/out_ready.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : operand handshake (accepted only in IDLE)
//   a, b, bin            : minuend, subtrahend, borrow-in
//   out_valid, out_ready : result handshake (held in DONE until accepted)
//   diff, bout           : WIDTH-bit difference, borrow-out
//   ovf                  : signed overflow, present only when
//                          SERIAL_SUBTRACTOR_OVF_EN is defined
//   busy                 : high in SHIFT or DONE
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_b;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  full_sub u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (r_q),
    .d    (cell_d),
    .bout (cell_b)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    amsb_d    = amsb_q;
    bmsb_d    = bmsb_q;
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          r_d     = bin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        r_d   = cell_b;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish only on the final bit so diff/bout never show a partial result.
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_b;
          state_d = DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d   = (amsb_q != bmsb_q) && (cell_d != amsb_q);
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Shift registers are fully reloaded on accept, so they need no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain modulo arithmetic and unsigned compare.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int v;
    v = int'(x) - int'(y) - int'(c);
    return W'(v);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return int'(x) < (int'(y) + int'(c));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W-1:0] dd;
    dd = ref_diff(x, y, c);
    return (x[W-1] != y[W-1]) && (dd[W-1] != x[W-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, measure latency, hold result for 'hold' cycles, handshake.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input int hold);
    int cyc;
    logic [W-1:0] ed;
    logic eb;
    ed = ref_diff(ta, tb_, tc);
    eb = ref_bout(ta, tb_, tc);
    out_ready = (hold == 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_in_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b1; a = ta; b = tb_; bin = tc;
    tick();
    in_valid = 1'b0; a = $urandom; b = $urandom; bin = $urandom;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != W) begin
      errors++;
      $display("FAIL latency a=%0d b=%0d: got %0d cycles want %0d", ta, tb_, cyc, W);
    end
    checks++;
    if (diff !== ed || bout !== eb) begin
      errors++;
      $display("FAIL result a=%0d b=%0d bin=%0d: got diff=%0d bout=%b want diff=%0d bout=%b",
               ta, tb_, tc, diff, bout, ed, eb);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checks++;
    if (ovf !== ref_ovf(ta, tb_, tc)) begin
      errors++;
      $display("FAIL ovf a=%0d b=%0d bin=%0d: got %b want %b", ta, tb_, tc, ovf, ref_ovf(ta, tb_, tc));
    end
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || diff !== ed || bout !== eb || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: got valid=%b diff=%0d bout=%b busy=%b want 1 %0d %b 1",
                 i, out_valid, diff, bout, busy, ed, eb);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake: got in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got in_ready=%b out_valid=%b busy=%b diff=%0d bout=%b want 1 0 0 0 0",
               in_ready, out_valid, busy, diff, bout);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_txn(4'd9, 4'd3, 1'b0, 0);
    run_txn(4'd3, 4'd9, 1'b0, 0);
    run_txn(4'd5, 4'd5, 1'b1, 0);
    run_txn(4'd0, 4'd0, 1'b0, 0);
    run_txn(4'd0, 4'd0, 1'b1, 0);
    run_txn(4'd7, 4'd7, 1'b0, 0);
    run_txn(4'b0111, 4'b1000, 1'b0, 0);
    run_txn(4'b1000, 4'b0001, 1'b0, 0);
    run_txn(4'd15, 4'd0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_txn(4'd9, 4'd3, 1'b1, 6);
    run_txn(4'd2, 4'd14, 1'b0, 3);
  endtask

  task automatic test_ignored_input();
    logic [W-1:0] ed;
    int cyc;
    ed = ref_diff(4'd12, 4'd5, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'd12; b = 4'd5; bin = 1'b0;
    tick();
    a = 4'd1; b = 4'd9; bin = 1'b1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL shift_in_ready: got in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    in_valid = 1'b1;
    tick();
    checks++;
    if (diff !== ed || bout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ignored_input: got diff=%0d bout=%b in_ready=%b valid=%b want %0d 0 0 1",
               diff, bout, in_ready, out_valid, ed);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    repeat (W + 2) tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_spurious_txn: got busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got in_ready=%b out_valid=%b busy=%b diff=%0d bout=%b want 1 0 0 0 0",
               in_ready, out_valid, busy, diff, bout);
    end
    repeat (W + 2) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_valid: got %b want 0", out_valid);
    end
    rst_n = 1'b1;
    tick();
    run_txn(4'd2, 4'd1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    int cyc;
    in_valid = 1'b1; a = 4'd6; b = 4'd1; bin = 1'b0;
    tick();
    gap = 1;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 50) begin
      tick();
      gap++;
      cyc++;
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (gap != W + 2) begin
      errors++;
      $display("FAIL throughput: got %0d cycles between accepts want %0d", gap, W + 2);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (diff !== ref_diff(4'd6, 4'd1, 1'b0) || bout !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_result: got diff=%0d bout=%b want %0d 0", diff, bout, ref_diff(4'd6, 4'd1, 1'b0));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignored_input();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
